dispense_scheduler: RTL and testbench
=====================================

DISPENSE_SCHEDULER -- requirements
Module: dispense_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SAMPLE_PERIOD  200_000_000  cycles between moisture evaluations
  TIMEOUT        1_000_000_000  max cycles waiting on dispenser done
  WET_TH         8'd192  moisture at or above this gives 0 marbles
  MID_TH         8'd128  at or above this (below WET_TH) gives 1 marble
  DRY_TH         8'd64  at or above this (below MID_TH) gives 2 marbles; below gives 3
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  system clock
  rst  in  1  asynchronous, active-low reset
  run  in  1  level; 1 = scheduler active, 0 = return to idle at next safe point
  moisture  in  8  sensor level, higher = wetter
  moisture_valid  in  1  one-cycle strobe qualifying moisture
  done_servo_marble  in  1  dispenser completion, level
  enable_servo_marble  out  1  dispenser enable, level
  marble  out  2  marble count to dispenser
  rearm_servo  out  1  one-cycle pulse clearing dispenser done
  busy  out  1  high in any state other than IDLE
  fault  out  1  sticky timeout flag
  dispense_total  out  8  saturating count of marbles commanded

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT_SAMPLE, DISPENSE, REARM, COOLDOWN and FAULT.
REQ-004 IDLE -> WAIT_SAMPLE SHALL occur when run=1; the cycle counter SHALL clear on entry.
REQ-005 In WAIT_SAMPLE, the first moisture_valid SHALL latch moisture, compute marble per REQ-006, and register it on marble in the next cycle.
REQ-006 The mapping SHALL use unsigned compares, with thresholds inclusive at the lower bound: >=WET_TH gives 0, >=MID_TH gives 1, >=DRY_TH gives 2, otherwise 3.
REQ-007 After REQ-005, a computed count of 0 SHALL go directly to COOLDOWN; a nonzero count SHALL go to DISPENSE.
REQ-008 In DISPENSE, enable_servo_marble SHALL be 1 and marble SHALL hold stable.
REQ-009 In DISPENSE, the first cycle with done_servo_marble=1 SHALL deassert enable in the next cycle and move to REARM; dispense_total SHALL increase by marble, saturating at 255.
REQ-010 REARM SHALL pulse rearm_servo for exactly one cycle, then wait for done_servo_marble=0 before going to COOLDOWN.
REQ-011 COOLDOWN SHALL count SAMPLE_PERIOD cycles, then go to WAIT_SAMPLE; moisture_valid strobes during COOLDOWN SHALL be ignored.
REQ-012 Timeout: a 32-bit wait counter SHALL run in DISPENSE and REARM; reaching TIMEOUT SHALL go to FAULT, set fault=1 and force enable=0.
REQ-013 FAULT SHALL be left only by reset; busy=1 in FAULT.
REQ-014 run=0: from WAIT_SAMPLE or COOLDOWN the FSM SHALL go to IDLE next cycle; DISPENSE and REARM SHALL complete first, then go to IDLE instead of COOLDOWN.
REQ-015 If moisture_valid and done_servo_marble events coincide, the current state SHALL decide which one is used; the other SHALL be dropped.
REQ-016 All outputs SHALL be registered; enable_servo_marble SHALL never be 1 in the same cycle as rearm_servo.

Reset
REQ-017 rst=0 SHALL immediately force: state=IDLE, enable_servo_marble=0, marble=0, rearm_servo=0, busy=0, fault=0, dispense_total=0, all counters=0.
REQ-018 Reset asserted mid-DISPENSE SHALL drop enable in that same cycle (asynchronously), with no rearm pulse.
REQ-019 Release of rst SHALL take effect on the next clk edge; with run=1 already high, the FSM SHALL enter WAIT_SAMPLE on that edge.

Verification
REQ-020 Wet sample: run=1, moisture=200 with valid -> marble=0, no enable, COOLDOWN for SAMPLE_PERIOD cycles, dispense_total=0.
REQ-021 Dry sample with normal handshake: moisture=10 -> marble=3, enable=1; done=1 after 50 cycles -> enable=0 next cycle, one rearm pulse; done=0 -> COOLDOWN; dispense_total=3.
REQ-022 Boundary values: moisture=64, 63, 128 and 192 -> marble=2, 3, 1 and 0 respectively.
REQ-023 Timeout: done held 0 with TIMEOUT=100 -> fault=1 at wait-counter 100, enable=0, FSM stays in FAULT until rst=0.
REQ-024 Saturation and abort: 86 dry cycles -> dispense_total=255 and stays there; run=0 during DISPENSE -> handshake completes, then IDLE, busy=0.
REQ-025 Reset during DISPENSE: rst=0 -> enable=0 with no clock edge; after release, all outputs at reset values.

Source files
------------

// File: rtl/dispense_scheduler.sv
// Moisture-driven marble dispense scheduler: samples a sensor, commands the dispenser,
// supervises its done/rearm handshake with a timeout, and keeps a saturating total.
module dispense_scheduler #(
  parameter int unsigned SAMPLE_PERIOD = 200_000_000,
  parameter int unsigned TIMEOUT       = 1_000_000_000,
  parameter logic [7:0]  WET_TH        = 8'd192,
  parameter logic [7:0]  MID_TH        = 8'd128,
  parameter logic [7:0]  DRY_TH        = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] moisture,
  input  logic       moisture_valid,
  input  logic       done_servo_marble,
  output logic       enable_servo_marble,
  output logic [1:0] marble,
  output logic       rearm_servo,
  output logic       busy,
  output logic       fault,
  output logic [7:0] dispense_total
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned TOT_W = 8;
  localparam int unsigned SUM_W = TOT_W + 1;
  localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SAMPLE,
    DISPENSE,
    REARM,
    COOLDOWN,
    FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       marble_c;
  logic [SUM_W-1:0] total_sum_c;
  logic             timed_out_c;

  // Wetter soil needs fewer marbles; each threshold is inclusive at its lower bound.
  always_comb begin
    if (moisture >= WET_TH)      marble_c = 2'd0;
    else if (moisture >= MID_TH) marble_c = 2'd1;
    else if (moisture >= DRY_TH) marble_c = 2'd2;
    else                         marble_c = 2'd3;
  end

  assign total_sum_c = {1'b0, dispense_total} + SUM_W'(marble);
  assign timed_out_c = (wait_cnt >= TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      cycle_cnt           <= '0;
      wait_cnt            <= '0;
      enable_servo_marble <= 1'b0;
      marble              <= '0;
      rearm_servo         <= 1'b0;
      busy                <= 1'b0;
      fault               <= 1'b0;
      dispense_total      <= '0;
    end else begin
      rearm_servo <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state     <= WAIT_SAMPLE;
            cycle_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        WAIT_SAMPLE: begin
          if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (moisture_valid) begin
            marble <= marble_c;
            if (marble_c == 2'd0) begin
              state     <= COOLDOWN;
              cycle_cnt <= '0;
            end else begin
              state               <= DISPENSE;
              enable_servo_marble <= 1'b1;
              wait_cnt            <= '0;
            end
          end
        end
        DISPENSE: begin
          // The wait counter keeps running through REARM so the whole handshake is bounded.
          if (done_servo_marble) begin
            state               <= REARM;
            enable_servo_marble <= 1'b0;
            rearm_servo         <= 1'b1;
            wait_cnt            <= wait_cnt + CNT_W'(1);
            dispense_total      <= total_sum_c[TOT_W] ? '1 : total_sum_c[TOT_W-1:0];
          end else if (timed_out_c) begin
            state               <= FAULT;
            enable_servo_marble <= 1'b0;
            fault               <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        REARM: begin
          if (!done_servo_marble) begin
            state     <= run ? COOLDOWN : IDLE;
            busy      <= run;
            cycle_cnt <= '0;
          end else if (timed_out_c) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        COOLDOWN: begin
          if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cycle_cnt >= SAMPLE_LAST) begin
            state <= WAIT_SAMPLE;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        FAULT: begin
          enable_servo_marble <= 1'b0;
          busy                <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_scheduler.sv
// Scoreboard bench for dispense_scheduler: randomized samples against a threshold and
// saturating-total reference model, with a reactive dispenser model on the handshake.
`timescale 1ns/1ps
module tb_dispense_scheduler;

  localparam int unsigned SP = 20;
  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] moisture = 8'd0;
  logic       moisture_valid = 1'b0;
  logic       done_servo_marble = 1'b0;
  logic       enable_servo_marble;
  logic [1:0] marble;
  logic       rearm_servo;
  logic       busy;
  logic       fault;
  logic [7:0] dispense_total;

  int n_checks = 0;
  int n_fail = 0;
  int model_total = 0;
  int q_marble[$];
  int q_total[$];
  bit disp_on = 1'b1;
  int disp_delay = 0;

  dispense_scheduler #(.SAMPLE_PERIOD(SP), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .run                 (run),
    .moisture            (moisture),
    .moisture_valid      (moisture_valid),
    .done_servo_marble   (done_servo_marble),
    .enable_servo_marble (enable_servo_marble),
    .marble              (marble),
    .rearm_servo         (rearm_servo),
    .busy                (busy),
    .fault               (fault),
    .dispense_total      (dispense_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference: one marble fewer for each threshold the reading reaches.
  function automatic int exp_marble(input int m);
    return 3 - int'(m >= 64) - int'(m >= 128) - int'(m >= 192);
  endfunction

  task automatic push_dispense(input int e);
    model_total = (model_total + e > 255) ? 255 : model_total + e;
    q_marble.push_back(e);
    q_total.push_back(model_total);
  endtask

  task automatic wait_handshake(input string name);
    int k;
    k = 0;
    while (!rearm_servo && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!rearm_servo) expire({name, "_rearm"});
    k = 0;
    while (done_servo_marble && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (done_servo_marble) expire({name, "_done_low"});
  endtask

  // Issue one strobe while the scheduler is waiting, then let it settle back to waiting.
  task automatic sample(input int m, input string name);
    int e;
    e = exp_marble(m);
    if (e != 0) push_dispense(e);
    moisture       = 8'(m);
    moisture_valid = 1'b1;
    @(negedge clk);
    moisture_valid = 1'b0;
    if (e == 0) begin
      check({name, "_wet_marble"}, int'(marble), 0);
      check({name, "_wet_total"}, int'(dispense_total), model_total);
    end else begin
      wait_handshake(name);
    end
    repeat (SP + 3) @(negedge clk);
  endtask

  // Dispenser: raise done some cycles after enable, drop it some cycles after rearm.
  initial begin : dispenser
    int d;
    int r;
    forever begin
      @(negedge clk);
      if (disp_on && enable_servo_marble && !done_servo_marble) begin
        d = (disp_delay > 0) ? disp_delay : int'($urandom_range(1, 8));
        repeat (d) @(negedge clk);
        if (enable_servo_marble) begin
          done_servo_marble = 1'b1;
          for (int k = 0; k < 50 && !rearm_servo; k++) @(negedge clk);
          r = int'($urandom_range(0, 4));
          repeat (r) @(negedge clk);
          done_servo_marble = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic p_en;
    logic p_rearm;
    int   cur_m;
    int   cur_t;
    p_en    = 1'b0;
    p_rearm = 1'b0;
    cur_m   = 0;
    cur_t   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("en_rearm_exclusive", int'(enable_servo_marble & rearm_servo), 0);
        if (enable_servo_marble && !p_en) begin
          if (q_marble.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_enable: marble=%0d with no pending dispense", marble);
          end else begin
            cur_m = q_marble.pop_front();
            cur_t = q_total.pop_front();
            check("dispense_marble", int'(marble), cur_m);
          end
        end else if (enable_servo_marble) begin
          check("marble_stable", int'(marble), cur_m);
        end
        if (p_en && done_servo_marble && !fault) begin
          check("enable_drop_on_done", int'(enable_servo_marble), 0);
          check("rearm_on_done", int'(rearm_servo), 1);
        end
        if (p_rearm) check("rearm_width", int'(rearm_servo), 0);
        if (rearm_servo) check("total_on_rearm", int'(dispense_total), cur_t);
      end
      p_en    = enable_servo_marble & rst;
      p_rearm = rearm_servo & rst;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int m;
    int bvals[4] = '{64, 63, 128, 192};

    #3 rst = 1'b0;
    #1;
    check("rst_enable", int'(enable_servo_marble), 0);
    check("rst_marble", int'(marble), 0);
    check("rst_rearm", int'(rearm_servo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_total", int'(dispense_total), 0);

    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    check("release_run_busy", int'(busy), 1);

    // Wet sample, then dry strobes held through the cooldown must be ignored.
    disp_delay     = 50;
    moisture       = 8'd200;
    moisture_valid = 1'b1;
    @(negedge clk);
    check("wet200_marble", int'(marble), 0);
    check("wet200_enable", int'(enable_servo_marble), 0);
    check("wet200_total", int'(dispense_total), 0);
    push_dispense(3);
    moisture = 8'd10;
    n = 1;
    while (!enable_servo_marble && n < int'(SP) + 20) begin
      @(negedge clk);
      n++;
    end
    moisture_valid = 1'b0;
    check("cooldown_length", n, int'(SP) + 2);
    wait_handshake("dry10");
    check("dry10_total", int'(dispense_total), 3);
    disp_delay = 0;
    repeat (SP + 3) @(negedge clk);

    foreach (bvals[i]) sample(bvals[i], "boundary");

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        m = int'(bvals[$urandom_range(0, 3)]) + int'($urandom_range(0, 2)) - 1;
      end else begin
        m = int'($urandom_range(0, 255));
      end
      sample(m, "random");
    end

    while (model_total < 255) sample(int'($urandom_range(0, 63)), "saturate");
    sample(10, "saturated");
    sample(0, "saturated");
    check("saturated_total", int'(dispense_total), 255);

    // Dropping run mid-dispense lets the handshake finish, then returns to idle.
    push_dispense(3);
    moisture       = 8'd10;
    moisture_valid = 1'b1;
    @(negedge clk);
    moisture_valid = 1'b0;
    if (!enable_servo_marble) expire("abort_enable");
    run = 1'b0;
    wait_handshake("abort");
    repeat (2) @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_enable", int'(enable_servo_marble), 0);
    check("abort_total", int'(dispense_total), model_total);
    run = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a dispense clears everything without a clock edge.
    disp_on = 1'b0;
    push_dispense(3);
    moisture       = 8'd10;
    moisture_valid = 1'b1;
    @(negedge clk);
    moisture_valid = 1'b0;
    if (!enable_servo_marble) expire("midrst_enable");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_enable", int'(enable_servo_marble), 0);
    check("midrst_rearm", int'(rearm_servo), 0);
    check("midrst_marble", int'(marble), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_total", int'(dispense_total), 0);
    model_total = 0;
    q_marble.delete();
    q_total.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_busy", int'(busy), 1);
    check("midrst_release_enable", int'(enable_servo_marble), 0);

    // Dispenser never answers: timeout after TO waiting cycles, sticky until reset.
    push_dispense(3);
    moisture       = 8'd10;
    moisture_valid = 1'b1;
    @(negedge clk);
    moisture_valid = 1'b0;
    if (!enable_servo_marble) expire("timeout_enable");
    n = 0;
    while (!fault && n < int'(TO) + 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, int'(TO));
    check("timeout_enable", int'(enable_servo_marble), 0);
    check("timeout_busy", int'(busy), 1);
    repeat (30) @(negedge clk);
    check("fault_sticky", int'(fault), 1);
    check("fault_busy", int'(busy), 1);
    check("fault_enable", int'(enable_servo_marble), 0);
    rst = 1'b0;
    #1;
    check("fault_cleared", int'(fault), 0);
    check("fault_rst_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
